// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC sequencing and instruction fetch with stall, redirect,
// misaligned-target trap and a saturating redirect counter.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             PCsrc,
    input  logic [31:0]      target,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             instr_valid,
    output logic             nop,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_count
);
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;
    logic             r_valid;
    logic             r_nop;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             w_live;
    logic             w_redirect;
    logic             w_misalign;

    // ERROR is terminal, so any redirect request there is simply dropped
    assign w_live     = r_state != S_ERR;
    assign w_redirect = w_live && PCsrc && target[1:0] == 2'b00;
    assign w_misalign = w_live && PCsrc && target[1:0] != 2'b00;

    assign imem_req       = r_state == S_REQ;
    assign imem_addr      = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign instr_valid    = r_valid;
    assign nop            = r_nop;
    assign misalign_err   = r_err;
    assign redirect_count = r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= RESET_PC;
            r_valid    <= 1'b0;
            r_nop      <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else if (!w_live) begin
            r_valid <= 1'b0;
            r_nop   <= 1'b1;
        end else if (w_misalign) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
            r_valid <= 1'b0;
            r_nop   <= 1'b1;
        end else if (w_redirect) begin
            r_pc    <= target;
            r_valid <= 1'b0;
            r_nop   <= 1'b1;
            r_state <= S_REQ;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end else begin
            r_nop <= 1'b0;
            if (r_state == S_BOOT) begin
                r_state <= S_REQ;
            end else if (r_state == S_HOLD) begin
                if (!stall) r_state <= S_REQ;
            end else if (stall) begin
                // with nothing live there is nothing to hold, so keep requesting
                if (r_valid) r_state <= S_HOLD;
            end else if (imem_ready) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
                r_valid    <= 1'b1;
                r_pc       <= r_pc + 32'd4;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenario tests for fetch_pc_unit.
module tb_fetch_pc_unit;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          PCsrc = 1'b0;
    logic [31:0]   target = 32'h0;
    logic          stall = 1'b0;
    logic          imem_ready = 1'b0;
    logic [31:0]   imem_rdata;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          nop;
    logic          misalign_err;
    logic [CW-1:0] redirect_count;
    int total = 0;
    int bad = 0;

    fetch_pc_unit #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .PCsrc(PCsrc), .target(target),
        .stall(stall), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .nop(nop),
        .misalign_err(misalign_err), .redirect_count(redirect_count)
    );

    always #5 clock = ~clock;

    // memory model: each word encodes its own address
    assign imem_rdata = 32'hC0DE_0000 ^ imem_addr;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCsrc = 1'b1; target = 32'h40; imem_ready = 1'b1;
        tick(); tick();
        PCsrc = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        total++; if (instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_ipc got=%h exp=0", instr_pc); end
        total++; if ({instr_valid, nop, misalign_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {instr_valid, nop, misalign_err}); end
        total++; if (redirect_count !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", redirect_count); end
    endtask

    task automatic test_fetch();
        reset = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL req_rise got=%b/%h exp=1/0", imem_req, imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL req_nvalid got=%b exp=0", instr_valid); end
        tick();
        total++; if (instr_pc !== 32'h0 || instr !== 32'hC0DE_0000 || instr_valid !== 1'b1) begin bad++; $display("FAIL fetch0 got=%h/%h/%b exp=0/c0de0000/1", instr_pc, instr, instr_valid); end
        tick();
        total++; if (instr_pc !== 32'h4 || instr !== 32'hC0DE_0004) begin bad++; $display("FAIL fetch4 got=%h/%h exp=4/c0de0004", instr_pc, instr); end
        tick();
        total++; if (instr_pc !== 32'h8 || imem_addr !== 32'hC) begin bad++; $display("FAIL fetch8 got=%h/%h exp=8/c", instr_pc, imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (instr_pc !== 32'h8 || instr !== 32'hC0DE_0008 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%b/%b exp=8/c0de0008/1/0", i, instr_pc, instr, instr_valid, imem_req); end
        end
        stall = 1'b0;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_pc !== 32'h8) begin bad++; $display("FAIL stall_resume got=%b/%h/%h exp=1/c/8", imem_req, imem_addr, instr_pc); end
        tick();
        total++; if (instr_pc !== 32'hC || instr !== 32'hC0DE_000C || imem_addr !== 32'h10) begin bad++; $display("FAIL stall_fetchc got=%h/%h/%h exp=c/c0de000c/10", instr_pc, instr, imem_addr); end
    endtask

    task automatic test_not_ready();
        imem_ready = 1'b0;
        tick();
        total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h10 || instr_pc !== 32'hC) begin bad++; $display("FAIL nrdy got=%b/%h/%h exp=0/10/c", instr_valid, imem_addr, instr_pc); end
        tick();
        total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin bad++; $display("FAIL nrdy_hold got=%h/%b exp=10/1", imem_addr, imem_req); end
        imem_ready = 1'b1;
    endtask

    task automatic test_redirect();
        PCsrc = 1'b1; target = 32'h100;
        tick();
        PCsrc = 1'b0;
        total++; if (nop !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flags got=%b/%b exp=1/0", nop, instr_valid); end
        total++; if (imem_addr !== 32'h100 || redirect_count !== 4'd1 || instr_pc !== 32'hC) begin bad++; $display("FAIL redir_pc got=%h/%0d/%h exp=100/1/c", imem_addr, redirect_count, instr_pc); end
        tick();
        total++; if (nop !== 1'b0 || instr_pc !== 32'h100 || instr_valid !== 1'b1 || imem_addr !== 32'h104) begin bad++; $display("FAIL redir_after got=%b/%h/%b/%h exp=0/100/1/104", nop, instr_pc, instr_valid, imem_addr); end
    endtask

    task automatic test_back_to_back();
        PCsrc = 1'b1; target = 32'h200;
        tick();
        total++; if (nop !== 1'b1 || imem_addr !== 32'h200 || redirect_count !== 4'd2) begin bad++; $display("FAIL b2b_first got=%b/%h/%0d exp=1/200/2", nop, imem_addr, redirect_count); end
        target = 32'h300;
        tick();
        PCsrc = 1'b0;
        total++; if (nop !== 1'b1 || imem_addr !== 32'h300 || redirect_count !== 4'd3 || instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b/%h/%0d/%b exp=1/300/3/0", nop, imem_addr, redirect_count, instr_valid); end
        tick();
        total++; if (nop !== 1'b0 || instr_pc !== 32'h300) begin bad++; $display("FAIL b2b_after got=%b/%h exp=0/300", nop, instr_pc); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        tick();
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL sr_hold got=%b/%b exp=0/1", imem_req, instr_valid); end
        PCsrc = 1'b1; target = 32'h400;
        tick();
        PCsrc = 1'b0; stall = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || redirect_count !== 4'd4 || nop !== 1'b1) begin bad++; $display("FAIL sr_redir got=%b/%h/%0d/%b exp=1/400/4/1", imem_req, imem_addr, redirect_count, nop); end
        tick();
        total++; if (instr_pc !== 32'h400) begin bad++; $display("FAIL sr_fetch got=%h exp=400", instr_pc); end
    endtask

    task automatic test_wrap();
        PCsrc = 1'b1; target = 32'hFFFF_FFFC;
        tick();
        PCsrc = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC || redirect_count !== 4'd5) begin bad++; $display("FAIL wrap_load got=%h/%0d exp=fffffffc/5", imem_addr, redirect_count); end
        tick();
        total++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_inc got=%h/%h exp=fffffffc/0", instr_pc, imem_addr); end
    endtask

    task automatic test_misalign();
        PCsrc = 1'b1; target = 32'h102;
        tick();
        total++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || nop !== 1'b1) begin bad++; $display("FAIL mis_set got=%b/%b/%b/%b exp=1/0/0/1", misalign_err, imem_req, instr_valid, nop); end
        total++; if (imem_addr !== 32'h0 || redirect_count !== 4'd5) begin bad++; $display("FAIL mis_pc got=%h/%0d exp=0/5", imem_addr, redirect_count); end
        target = 32'h200;
        tick(); tick();
        PCsrc = 1'b0;
        total++; if (imem_addr !== 32'h0 || redirect_count !== 4'd5 || misalign_err !== 1'b1 || imem_req !== 1'b0 || nop !== 1'b1) begin bad++; $display("FAIL err_ignore got=%h/%0d/%b/%b/%b exp=0/5/1/0/1", imem_addr, redirect_count, misalign_err, imem_req, nop); end
        reset = 1'b1; PCsrc = 1'b1; target = 32'h40;
        tick();
        PCsrc = 1'b0; reset = 1'b0;
        total++; if (misalign_err !== 1'b0 || imem_addr !== 32'h0 || redirect_count !== 4'd0 || nop !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL err_reset got=%b/%h/%0d/%b/%b exp=0/0/0/0/0", misalign_err, imem_addr, redirect_count, nop, imem_req); end
    endtask

    task automatic test_saturate();
        PCsrc = 1'b1; target = 32'h1000;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000 || redirect_count !== 4'd1) begin bad++; $display("FAIL boot_redir got=%b/%h/%0d exp=1/1000/1", imem_req, imem_addr, redirect_count); end
        for (int i = 1; i < 18; i++) begin
            target = 32'h1000 + 32'(i * 4);
            tick();
            if (i == 14) begin
                total++; if (redirect_count !== 4'd15) begin bad++; $display("FAIL sat_reach got=%0d exp=15", redirect_count); end
            end
        end
        PCsrc = 1'b0;
        total++; if (redirect_count !== 4'd15 || imem_addr !== 32'h1044) begin bad++; $display("FAIL sat_hold got=%0d/%h exp=15/1044", redirect_count, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_not_ready();
        test_redirect();
        test_back_to_back();
        test_stall_redirect();
        test_wrap();
        test_misalign();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16: width of the redirect counter.
REQ-003 clock  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 PCsrc  input  1  redirect request from the branch unit; 1 = load target.
REQ-006 target  input  32  redirect destination PC, sampled only when PCsrc=1.
REQ-007 stall  input  1  downstream not ready; hold the presented instruction.
REQ-008 imem_ready  input  1  instruction memory has the requested word on imem_rdata this cycle.
REQ-009 imem_rdata  input  32  instruction word, valid only when imem_ready=1.
REQ-010 imem_req  output  1  fetch request; imem_addr valid while high.
REQ-011 imem_addr  output  32  fetch address, equal to the PC register.
REQ-012 instr  output  32  registered instruction presented downstream.
REQ-013 instr_pc  output  32  address from which instr was fetched.
REQ-014 instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-015 nop  output  1  one-cycle flush marker to the decode and branch stages.
REQ-016 misalign_err  output  1  sticky flag for a redirect target with target[1:0]!=0.
REQ-017 redirect_count  output  CNT_W  number of accepted redirects, saturating.

Function
REQ-018 The state machine SHALL have the states BOOT, REQ, HOLD and ERROR, all encoded in one registered state variable.
REQ-019 BOOT: imem_req=0 for exactly one cycle after reset, then unconditional transition to REQ.
REQ-020 REQ: imem_req=1, imem_addr=pc.
- imem_ready=1 and stall=0 and PCsrc=0: capture instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4; remain in REQ.
- stall=1 with instr_valid=1: transition to HOLD without accepting new data.
REQ-021 HOLD: imem_req=0; instr, instr_pc and instr_valid held stable; return to REQ in the cycle after stall falls.
REQ-022 In REQ, when imem_ready=0, the unit SHALL keep pc and imem_addr stable, and instr_valid SHALL fall to 0 unless stall=1.
REQ-023 The pc+4 increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-024 Redirect on PCsrc=1 in REQ or HOLD with target[1:0]==2'b00:
- pc<=target.
- instr_valid<=0 on the next edge.
- nop=1 for exactly the next cycle.
- redirect_count increments.
- next state is REQ.
REQ-025 PCsrc SHALL take priority over stall and over imem_ready; a word returned in the same cycle as PCsrc SHALL be discarded, not captured.
REQ-026 Consecutive PCsrc cycles: each SHALL be a separate redirect, the last target wins, and nop stays 1 for the cycle after each.
REQ-027 PCsrc in BOOT SHALL be applied as in REQ-024, and the BOOT->REQ transition SHALL still occur.
REQ-028 Misaligned target: PCsrc=1 with target[1:0]!=0 SHALL set misalign_err=1.
- pc is left unchanged.
- Next state is ERROR; instr_valid<=0, nop<=1.
- redirect_count does not increment.
REQ-029 ERROR: imem_req=0, instr_valid=0, nop=1, PCsrc ignored; exit only by reset.
REQ-030 redirect_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 PCsrc is evaluated on the rising edge only; no output depends on the falling edge.

Reset
REQ-032 On reset=1 at a rising edge, the unit SHALL load the reset values, overriding all other inputs:
- pc=RESET_PC, state=BOOT.
- instr=32'h0000_0013 (NOP), instr_pc=RESET_PC.
- instr_valid=0, nop=0, misalign_err=0, redirect_count=0.
REQ-033 Reset asserted in the middle of a fetch or redirect SHALL discard the in-flight fetch and the pending redirect.

Verification
REQ-034 Reset then imem_ready=1 constant, stall=0:
- imem_req rises in cycle 2.
- instr_pc shows 0x0, 0x4, 0x8 on successive cycles with instr_valid=1.
REQ-035 stall=1 for 3 cycles while instr_pc=0x8:
- instr and instr_pc stay at 0x8 and imem_req=0 during the stall.
- Fetch of 0xC resumes one cycle after stall falls.
REQ-036 PCsrc=1, target=0x100, with imem_ready=1 in the same cycle:
- The word on imem_rdata is discarded.
- nop=1 and instr_valid=0 the next cycle, imem_addr=0x100, redirect_count=1.
REQ-037 PCsrc=1, target=0x102:
- misalign_err=1, ERROR entered, imem_req=0.
- A later PCsrc is ignored; after reset misalign_err=0 and pc=RESET_PC.
REQ-038 Preload pc=32'hFFFF_FFFC via a redirect, then fetch: next imem_addr=0x0000_0000.
REQ-039 Issue 2^CNT_W+2 redirects: redirect_count holds at 2^CNT_W-1.
